// File: rtl/nios_qsys_light_out.sv
// Avalon-MM output PIO for light lines: static DATA bits or a shared PWM
// selected per line by MASK, with optional burst count, sticky done and irq.
module nios_qsys_light_out #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               run_q, run_d;

  logic [WIDTH-1:0]   data_r, mask_r;
  logic [CNT_W-1:0]   period_r, duty_r, burst_r;
  logic               irq_en_r;
  logic [31:0]        rd_mux;
  logic               wr, wr_ctrl, wr_status, busy, pwm;
  logic               unused_wdata;

  assign wr           = chipselect && !write_n;
  assign wr_ctrl      = wr && (address == 3'd4);
  assign wr_status    = wr && (address == 3'd6);
  assign busy         = (state_q == RUN);
  assign pwm          = busy && (cnt_q < duty_r);
  assign irq          = done_q & irq_en_r;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r   <= '0;
      mask_r   <= '0;
      period_r <= '0;
      duty_r   <= '0;
      burst_r  <= '0;
      irq_en_r <= 1'b0;
    end else if (wr) begin
      case (address)
        3'd0: data_r   <= writedata[WIDTH-1:0];
        3'd1: period_r <= writedata[CNT_W-1:0];
        3'd2: duty_r   <= writedata[CNT_W-1:0];
        3'd3: mask_r   <= writedata[WIDTH-1:0];
        3'd4: irq_en_r <= writedata[1];
        3'd5: burst_r  <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      run_q   <= run_d;
    end
  end

  // STATUS clear is applied first so a completing burst on the same edge wins;
  // a CONTROL write is applied last so it overrides completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    done_d  = done_q;
    run_d   = run_q;
    if (wr_status) done_d = 1'b0;
    if (state_q == RUN) begin
      if (cnt_q == period_r) begin
        cnt_d = '0;
        if (rem_q != '0) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            run_d   = 1'b0;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (wr_ctrl) begin
      run_d = writedata[0];
      if (writedata[0]) begin
        state_d = RUN;
        cnt_d   = '0;
        rem_d   = burst_r;
        done_d  = done_q;
      end else if (state_q == RUN) begin
        state_d = IDLE;
        cnt_d   = '0;
        rem_d   = rem_q;
        done_d  = done_q;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = 32'(data_r);
      3'd1: rd_mux = 32'(period_r);
      3'd2: rd_mux = 32'(duty_r);
      3'd3: rd_mux = 32'(mask_r);
      3'd4: rd_mux = {30'd0, irq_en_r, run_q};
      3'd5: rd_mux = 32'(rem_q);
      3'd6: rd_mux = {30'd0, busy, done_q};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= '0;
    end else begin
      readdata <= rd_mux;
      out_port <= (data_r & ~mask_r) | (mask_r & {WIDTH{pwm}});
    end
  end

endmodule
